// File: rtl/spi_top_core_if.sv
// SPI pin bundle between an external mode-0 SPI master and spi_top_core.
//   spi_sclk, spi_cs, spi_sdi0..3 : driven by the master
//   spi_mode, spi_sdo0..3         : driven by the core
interface spi_top_core_if;
   logic       spi_sclk;
   logic       spi_cs;
   logic [1:0] spi_mode;
   logic       spi_sdi0;
   logic       spi_sdi1;
   logic       spi_sdi2;
   logic       spi_sdi3;
   logic       spi_sdo0;
   logic       spi_sdo1;
   logic       spi_sdo2;
   logic       spi_sdo3;

   modport master (
      output spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
      input  spi_mode, spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3
   );

   modport slave (
      input  spi_sclk, spi_cs, spi_sdi0, spi_sdi1, spi_sdi2, spi_sdi3,
      output spi_mode, spi_sdo0, spi_sdo1, spi_sdo2, spi_sdo3
   );
endinterface

// File: rtl/spi_top_core.sv
// SPI-controlled configuration core. An external mode-0 SPI master reads and
// writes three 32-bit registers and a small word memory; reg2 drives gpio_o.
// SPI pins are oversampled on clk_i.
//   clk_i, rst_i         : system clock, async active-high reset
//   fetch_enable_i       : status, reg0 read bit 0
//   en_ifetch_i          : status, reg0 read bit 1
//   spi                  : SPI pin bundle (slave side)
//   gpio_o               : mirror of reg2
module spi_top_core #(
   parameter int unsigned MEM_WORDS  = 16,
   parameter logic [31:0] REG1_RESET = 32'd32
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           fetch_enable_i,
   input  logic           en_ifetch_i,
   spi_top_core_if.slave  spi,
   output logic [31:0]    gpio_o
);

   localparam int unsigned DW = 32;
   localparam int unsigned AW = $clog2(MEM_WORDS);
   localparam int unsigned CW = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
   } state_t;

   typedef enum logic [1:0] {T_REG0, T_REG1, T_REG2, T_MEM} tgt_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [DW-1:0]   sin, sin_n;
   logic [DW-1:0]   sout, sout_n;
   logic            sdo, sdo_n;
   tgt_t            tgt, tgt_n;
   logic            mem_rd, mem_rd_n;
   logic [AW-1:0]   idx, idx_n;
   logic            wr_en, wr_en_n;

   logic [DW-1:0]   reg0, reg1, reg2;
   logic [DW-1:0]   mem [MEM_WORDS];

   logic [1:0]      sclk_q, cs_q, sdi_q;
   logic            sclk_d, cs_d;
   logic            sclk_s, cs_s, sdi_s;
   logic            sclk_rise, sclk_fall, cs_fall;
   logic [CW-1:0]   cmd_word;
   logic [DW-1:0]   data_word;
   logic            unused_sig;

   assign spi.spi_mode = 2'b00;
   assign spi.spi_sdo0 = sdo;
   assign spi.spi_sdo1 = 1'b0;
   assign spi.spi_sdo2 = 1'b0;
   assign spi.spi_sdo3 = 1'b0;
   assign gpio_o       = reg2;

   assign unused_sig = ^{spi.spi_sdi1, spi.spi_sdi2, spi.spi_sdi3, reg0[1:0]};

   // Two-flop synchronizers plus one delay stage for edge detection.
   // cs resets high so leaving reset never looks like a cs fall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_q <= 2'b00;
         cs_q   <= 2'b11;
         sdi_q  <= 2'b00;
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_q <= {sclk_q[0], spi.spi_sclk};
         cs_q   <= {cs_q[0], spi.spi_cs};
         sdi_q  <= {sdi_q[0], spi.spi_sdi0};
         sclk_d <= sclk_q[1];
         cs_d   <= cs_q[1];
      end
   end

   assign sclk_s    = sclk_q[1];
   assign cs_s      = cs_q[1];
   assign sdi_s     = sdi_q[1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_fall   = ~cs_s & cs_d;

   // Shift register contents including the bit being captured this cycle.
   assign cmd_word  = {sin[CW-2:0], sdi_s};
   assign data_word = {sin[DW-2:0], sdi_s};

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_n;
   end

   // Transaction datapath registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt    <= '0;
         sin    <= '0;
         sout   <= '0;
         sdo    <= 1'b0;
         tgt    <= T_REG0;
         mem_rd <= 1'b0;
         idx    <= '0;
         wr_en  <= 1'b0;
      end else begin
         cnt    <= cnt_n;
         sin    <= sin_n;
         sout   <= sout_n;
         sdo    <= sdo_n;
         tgt    <= tgt_n;
         mem_rd <= mem_rd_n;
         idx    <= idx_n;
         wr_en  <= wr_en_n;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      sin_n    = sin;
      sout_n   = sout;
      sdo_n    = sdo;
      tgt_n    = tgt;
      mem_rd_n = mem_rd;
      idx_n    = idx;
      wr_en_n  = 1'b0;

      if (cs_s) begin
         state_n = S_IDLE;
         sdo_n   = 1'b0;
      end else if (cs_fall) begin
         state_n = S_CMD;
         cnt_n   = '0;
         sdo_n   = 1'b0;
      end else begin
         if (sclk_rise) begin
            cnt_n = cnt + CW'(1);
            if (state inside {S_CMD, S_ADDR, S_WDATA}) sin_n = data_word;
         end

         case (state)
            S_CMD: begin
               if (sclk_rise && cnt == CW'(7)) begin
                  cnt_n = '0;
                  case (cmd_word)
                     8'h01: begin state_n = S_WDATA; tgt_n = T_REG0; end
                     8'h11: begin state_n = S_WDATA; tgt_n = T_REG1; end
                     8'h20: begin state_n = S_WDATA; tgt_n = T_REG2; end
                     8'h05: begin
                        state_n = S_RDATA;
                        sout_n  = {reg0[DW-1:2], en_ifetch_i, fetch_enable_i};
                     end
                     8'h07: begin state_n = S_RDATA; sout_n = reg1; end
                     8'h21: begin state_n = S_RDATA; sout_n = reg2; end
                     8'h02: begin state_n = S_ADDR; mem_rd_n = 1'b0; end
                     8'h0B: begin state_n = S_ADDR; mem_rd_n = 1'b1; end
                     default: state_n = S_IGNORE;
                  endcase
               end
            end

            S_ADDR: begin
               if (sclk_rise && cnt == CW'(DW - 1)) begin
                  cnt_n = '0;
                  idx_n = data_word[2 +: AW];
                  if (!mem_rd) begin
                     state_n = S_WDATA;
                     tgt_n   = T_MEM;
                  end else if (reg1[CW-1:0] == '0) begin
                     state_n = S_RDATA;
                     sout_n  = mem[data_word[2 +: AW]];
                  end else begin
                     state_n = S_DUMMY;
                  end
               end
            end

            S_DUMMY: begin
               if (sclk_rise && cnt == reg1[CW-1:0] - CW'(1)) begin
                  cnt_n   = '0;
                  state_n = S_RDATA;
                  sout_n  = mem[idx];
               end
            end

            S_WDATA: begin
               // Commit is issued one cycle after the last data bit lands.
               if (sclk_rise && cnt == CW'(DW - 1)) begin
                  wr_en_n = 1'b1;
                  state_n = S_IGNORE;
               end
            end

            S_RDATA: begin
               if (sclk_fall) begin
                  sdo_n  = sout[DW-1];
                  sout_n = {sout[DW-2:0], 1'b0};
               end
               if (sclk_rise && cnt == CW'(DW - 1)) begin
                  state_n = S_IGNORE;
                  sdo_n   = 1'b0;
               end
            end

            default: sdo_n = 1'b0;
         endcase
      end
   end

   // Configuration registers and memory.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         reg0 <= '0;
         reg1 <= REG1_RESET;
         reg2 <= '0;
         for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] <= '0;
      end else if (wr_en) begin
         case (tgt)
            T_REG0:  reg0     <= sin;
            T_REG1:  reg1     <= sin;
            T_REG2:  reg2     <= sin;
            default: mem[idx] <= sin;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_top_core.sv
// Self-checking bench for spi_top_core: a bit-banged SPI master runs a table
// of register/memory transactions, then hand-written corner sequences.
module tb_spi_top_core;

   localparam int HALF = 6;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        fetch_enable_i;
   logic        en_ifetch_i;
   logic [31:0] gpio_o;

   spi_top_core_if sif ();

   spi_top_core #(.MEM_WORDS(16), .REG1_RESET(32'd32)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .fetch_enable_i (fetch_enable_i),
      .en_ifetch_i    (en_ifetch_i),
      .spi            (sif),
      .gpio_o         (gpio_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] v;
   } sb_t;
   sb_t exp_q[$];

   // op: 0 reg write, 1 reg read, 2 mem write, 3 mem read
   typedef struct {
      string       name;
      int          op;
      logic [7:0]  cmd;
      logic [31:0] addr;
      logic [31:0] data;
      int          dummy;
      logic        fe;
      logic        ei;
      logic [31:0] gexp;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sclk_bit(input logic mosi, output logic miso);
      sif.spi_sdi0 = mosi;
      repeat (HALF) @(negedge clk_i);
      miso = sif.spi_sdo0;
      sif.spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk_i);
      sif.spi_sclk = 1'b0;
   endtask

   task automatic send(input logic [39:0] v, input int n);
      logic m;
      for (int i = n - 1; i >= 0; i--) sclk_bit(v[i], m);
   endtask

   task automatic recv(output logic [39:0] v, input int n);
      logic m;
      v = '0;
      for (int i = n - 1; i >= 0; i--) begin
         sclk_bit(1'b0, m);
         v[i] = m;
      end
   endtask

   task automatic cs_start();
      sif.spi_cs = 1'b0;
      repeat (HALF) @(negedge clk_i);
   endtask

   task automatic cs_end();
      repeat (HALF) @(negedge clk_i);
      sif.spi_cs   = 1'b1;
      sif.spi_sdi0 = 1'b0;
      repeat (HALF) @(negedge clk_i);
   endtask

   // Pops the oldest expected read and compares it with what the master saw.
   task automatic sb_compare(input logic [31:0] got);
      sb_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: got %h expected nothing queued", got);
      end else begin
         checks--;
         e = exp_q.pop_front();
         check(e.name, got, e.v);
      end
   endtask

   task automatic reg_write(input logic [7:0] cmd, input logic [31:0] data);
      cs_start();
      send({32'h0, cmd}, 8);
      send({8'h0, data}, 32);
      cs_end();
   endtask

   task automatic reg_read(input logic [7:0] cmd, output logic [31:0] data);
      logic [39:0] v;
      cs_start();
      send({32'h0, cmd}, 8);
      recv(v, 32);
      cs_end();
      data = v[31:0];
   endtask

   task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
      cs_start();
      send(40'h02, 8);
      send({8'h0, addr}, 32);
      send({8'h0, data}, 32);
      cs_end();
   endtask

   task automatic mem_read(input logic [31:0] addr, input int dummy, output logic [31:0] data);
      logic [39:0] v;
      cs_start();
      send(40'h0B, 8);
      send({8'h0, addr}, 32);
      for (int i = 0; i < dummy; i++) send(40'h0, 1);
      recv(v, 32);
      cs_end();
      data = v[31:0];
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic [39:0] v;
      logic        m;

      rst_i          = 1'b1;
      fetch_enable_i = 1'b0;
      en_ifetch_i    = 1'b0;
      sif.spi_sclk   = 1'b0;
      sif.spi_cs     = 1'b1;
      sif.spi_sdi0   = 1'b0;
      sif.spi_sdi1   = 1'b0;
      sif.spi_sdi2   = 1'b0;
      sif.spi_sdi3   = 1'b0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (2) @(negedge clk_i);

      check("rst_gpio", gpio_o, 32'h0);
      check("rst_sdo", {31'h0, sif.spi_sdo0}, 32'h0);
      check("rst_mode", {30'h0, sif.spi_mode}, 32'h0);
      check("rst_sdo123", {29'h0, sif.spi_sdo1, sif.spi_sdo2, sif.spi_sdo3}, 32'h0);

      vecs[0]  = '{"rd_reg1_reset",  1, 8'h07, 32'h0,   32'h0000_0020, 0,  1'b0, 1'b0, 32'h0};
      vecs[1]  = '{"wr_reg2",        0, 8'h20, 32'h0,   32'hA5A5_0F0F, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[2]  = '{"rd_reg2",        1, 8'h21, 32'h0,   32'hA5A5_0F0F, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[3]  = '{"wr_reg0",        0, 8'h01, 32'h0,   32'hFFFF_FFFC, 0,  1'b1, 1'b0, 32'hA5A5_0F0F};
      vecs[4]  = '{"rd_reg0_fe",     1, 8'h05, 32'h0,   32'hFFFF_FFFD, 0,  1'b1, 1'b0, 32'hA5A5_0F0F};
      vecs[5]  = '{"rd_reg0_ei",     1, 8'h05, 32'h0,   32'hFFFF_FFFE, 0,  1'b0, 1'b1, 32'hA5A5_0F0F};
      vecs[6]  = '{"wr_mem8",        2, 8'h02, 32'h8,   32'h1234_5678, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[7]  = '{"rd_mem8_d32",    3, 8'h0B, 32'h8,   32'h1234_5678, 32, 1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[8]  = '{"wr_reg1_zero",   0, 8'h11, 32'h0,   32'h0,         0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[9]  = '{"rd_reg1_zero",   1, 8'h07, 32'h0,   32'h0,         0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[10] = '{"rd_mem8_d0",     3, 8'h0B, 32'h8,   32'h1234_5678, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[11] = '{"wr_mem3c",       2, 8'h02, 32'h3C,  32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[12] = '{"rd_mem3c_d0",    3, 8'h0B, 32'h3C,  32'hDEAD_BEEF, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[13] = '{"rd_mem0_d0",     3, 8'h0B, 32'h0,   32'h0,         0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[14] = '{"rd_mem108_alias",3, 8'h0B, 32'h108, 32'h1234_5678, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[15] = '{"wr_reg1_three",  0, 8'h11, 32'h0,   32'h0000_0003, 0,  1'b0, 1'b0, 32'hA5A5_0F0F};
      vecs[16] = '{"rd_mem3c_d3",    3, 8'h0B, 32'h3C,  32'hDEAD_BEEF, 3,  1'b0, 1'b0, 32'hA5A5_0F0F};

      foreach (vecs[i]) begin
         fetch_enable_i = vecs[i].fe;
         en_ifetch_i    = vecs[i].ei;
         case (vecs[i].op)
            0: reg_write(vecs[i].cmd, vecs[i].data);
            1: begin
               exp_q.push_back('{vecs[i].name, vecs[i].data});
               reg_read(vecs[i].cmd, rd);
               sb_compare(rd);
            end
            2: mem_write(vecs[i].addr, vecs[i].data);
            default: begin
               exp_q.push_back('{vecs[i].name, vecs[i].data});
               mem_read(vecs[i].addr, vecs[i].dummy, rd);
               sb_compare(rd);
            end
         endcase
         check({vecs[i].name, "_gpio"}, gpio_o, vecs[i].gexp);
      end
      fetch_enable_i = 1'b0;
      en_ifetch_i    = 1'b0;

      // Extra bits after a full write are ignored; the 32 data bits commit.
      cs_start();
      send(40'h20, 8);
      send({32'h1357_9BDF, 8'hFF}, 40);
      cs_end();
      check("overlong_wr_gpio", gpio_o, 32'h1357_9BDF);

      // Read past 32 bits: sdo0 must fall to 0 for the trailing bits.
      exp_q.push_back('{"overlong_rd", 32'h1357_9BDF});
      cs_start();
      send(40'h21, 8);
      recv(v, 40);
      cs_end();
      sb_compare(v[39:8]);
      check("overlong_rd_tail", {24'h0, v[7:0]}, 32'h0);

      // Reset in the middle of a reg2 write.
      cs_start();
      send(40'h20, 8);
      send(40'hFFFF, 16);
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("midrst_gpio", gpio_o, 32'h0);
      check("midrst_sdo", {31'h0, sif.spi_sdo0}, 32'h0);
      rst_i = 1'b0;
      cs_end();
      exp_q.push_back('{"midrst_reg1", 32'h0000_0020});
      reg_read(8'h07, rd);
      sb_compare(rd);
      exp_q.push_back('{"midrst_mem8", 32'h0});
      mem_read(32'h8, 32, rd);
      sb_compare(rd);

      // cs raised after 16 data bits: no commit.
      cs_start();
      send(40'h20, 8);
      send(40'hBEEF, 16);
      cs_end();
      repeat (4) @(negedge clk_i);
      check("partial_wr_gpio", gpio_o, 32'h0);
      exp_q.push_back('{"partial_wr_reg2", 32'h0});
      reg_read(8'h21, rd);
      sb_compare(rd);

      // Unknown command: sdo0 held low for 40 clocks, nothing changes.
      cs_start();
      send(40'hFF, 8);
      recv(v, 40);
      cs_end();
      check("ign_sdo_hi", v[39:8], 32'h0);
      check("ign_sdo_lo", {24'h0, v[7:0]}, 32'h0);
      check("ign_gpio", gpio_o, 32'h0);
      exp_q.push_back('{"ign_reg1", 32'h0000_0020});
      reg_read(8'h07, rd);
      sb_compare(rd);

      // Scoreboard should be drained.
      check("sb_empty", 32'(exp_q.size()), 32'h0);

      m = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_top_core.md
# spi_top_core

SPI-controlled top-level core block. An external SPI master uses single-bit mode-0 SPI to read and write three 32-bit configuration registers and a 16-word internal memory. All logic runs on one system clock; SPI pins are oversampled. Register 2 drives the GPIO output bus.

## Interface
Parameters:
- MEM_WORDS, 16, internal memory depth (32-bit words, indexed by addr[5:2])
- REG1_RESET, 32, reset value of reg1 (memory-read dummy-cycle count)

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset; one clock; reset is asynchronous and active-high
- fetch_enable_i  in  1  status input, visible in reg0 read bit 0
- en_ifetch_i  in  1  status input, visible in reg0 read bit 1
- spi_sclk  in  1  SPI clock from master, CPOL=0/CPHA=0
- spi_cs  in  1  chip select, active-low
- spi_mode  out  2  constant 2'b00 (standard single-bit mode)
- spi_sdi0  in  1  serial data in (MOSI)
- spi_sdi1..spi_sdi3  in  1 each  unused, ignored
- spi_sdo0  out  1  serial data out (MISO)
- spi_sdo1..spi_sdo3  out  1 each  constant 0
- gpio_o  out  32  mirrors reg2

## Operation
- Synchronize spi_sclk, spi_cs and spi_sdi0 with 2-flop synchronizers into clk_i. Detect edges on the synchronized sclk.
- Sample sdi0 on each sclk rising edge while cs is low. Update sdo0 on each sclk falling edge. Both directions are MSB-first.
- A falling edge on cs starts a transaction: bit counter cleared, state CMD.
- States: IDLE, CMD (8 bits), ADDR (32 bits), DUMMY (reg1[7:0] sclk cycles), WDATA (32 bits), RDATA (32 bits), IGNORE.
- Commands:
  - 0x01: write reg0, CMD→WDATA.
  - 0x05: read reg0, CMD→RDATA. Read value is {reg0[31:2], en_ifetch_i, fetch_enable_i}, sampled when the 8th command bit is captured.
  - 0x11: write reg1.
  - 0x07: read reg1.
  - 0x20: write reg2.
  - 0x21: read reg2.
  - 0x02: write memory, CMD→ADDR→WDATA; word mem[addr[5:2]].
  - 0x0B: read memory, CMD→ADDR→DUMMY→RDATA. DUMMY is skipped when reg1[7:0]=0.
  - Any other command: IGNORE until cs rises; sdo0=0.
- Register and memory writes commit on the clk_i cycle after the 32nd WDATA rising edge. Further bits go to IGNORE.
- After the 32nd RDATA bit, go to IGNORE; sdo0=0.
- cs high at any time: return to IDLE, discard partial command/address/data (no commit), sdo0=0.
- Only one transaction is active at a time. A new cs fall restarts in CMD.

## Timing
- Reset values:
  - reg0=0, reg1=REG1_RESET (32), reg2=0, all memory words=0.
  - gpio_o=0, spi_sdo0=0, spi_mode=0, sdo1..3=0, state IDLE.
- Minimum SPI timing: sclk high and low phases each ≥4 clk_i periods. cs setup/hold to the first/last sclk edge ≥4 clk_i periods.
- Read data: MSB is driven on sdo0 within 3 clk_i cycles after the sclk falling edge that follows the last CMD bit (register read) or the last DUMMY/ADDR bit (memory read). The master samples it on the next rising edge.
- gpio_o updates in the same cycle that reg2 commits.
- Reset asserted mid-transaction: immediate return to reset values. Transaction lost; master must reassert cs.

## Test plan
- Reset, then read reg1 (cmd 0x07, 32 read bits) → 0x00000020; gpio_o=0.
- Write reg2 (0x20, data 0xA5A5_0F0F), then read with 0x21 → gpio_o=0xA5A50F0F and read returns 0xA5A50F0F.
- Set fetch_enable_i=1, en_ifetch_i=0; write reg0=0xFFFFFFFC; read with 0x05 → 0xFFFFFFFD.
- Write mem (0x02, addr 0x0000_0008, data 0x1234_5678); read with 0x0B at addr 8 using 32 dummy cycles → 0x12345678. Then write reg1=0 and read again with no dummy cycles → 0x12345678.
- Write 0x20 with cs raised after 16 data bits → reg2 and gpio_o unchanged (0).
- Command 0xFF followed by 40 sclk cycles → sdo0 stays 0; no register changes. The next 0x07 read returns 32.
